// File: rtl/npu_inst_fetch.sv
// Instruction fetch/decode stage feeding the NPU scheduler: reads one word from instruction SRAM
// per request, decodes the control fields and presents them with a one-cycle valid pulse.
module npu_inst_fetch #(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned PROG_LEN = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_fetch_en,
    input  logic [11:0]       i_pc,
    output logic              o_imem_ce,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_rdata,
    input  logic              i_imem_rerr,
    output logic              o_inst_valid,
    output logic [4:0]        o_opcode,
    output logic              o_be_noblock,
    output logic              o_wait_last_noblock_dma,
    output logic [11:0]       o_jump_pc,
    output logic [31:0]       o_inst_word,
    output logic              o_err_inst,
    output logic              o_busy,
    output logic              o_fetch_ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DEC  = 2'd3;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    logic [1:0]  r_state;
    logic [11:0] r_pc;
    logic        r_pend;
    logic [11:0] r_pend_pc;
    logic [1:0]  r_cnt;
    logic        r_ovf;

    logic [4:0]  r_opcode;
    logic        r_noblock;
    logic        r_wait_dma;
    logic [11:0] r_jump_pc;
    logic [31:0] r_word;
    logic        r_err;

    logic [1:0]  w_state_nxt;
    logic [11:0] w_pc_nxt;
    logic        w_pend_nxt;
    logic [11:0] w_pend_pc_nxt;
    logic [1:0]  w_cnt_nxt;
    logic        w_ovf_nxt;
    logic        w_capture;

    logic        w_oor;
    logic        w_illegal;
    logic [4:0]  w_dec_opcode;
    logic        w_dec_noblock;
    logic        w_dec_wait_dma;
    logic [11:0] w_dec_jump_pc;
    logic [31:0] w_dec_word;
    logic        w_dec_err;

    // r_pc is stable from REQ through WAIT, so the range check can be combinational.
    assign w_oor = ({20'd0, r_pc} >= PROG_LEN);

    always_comb begin
        w_illegal = 1'b1;
        case (i_imem_rdata[31:27])
            5'b01010, 5'b01011, 5'b01101, 5'b10010, 5'b11100,
            5'b00110, 5'b11111, 5'b10011, 5'b10110, 5'b10111: w_illegal = 1'b0;
            default:                                          w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_dec_opcode   = 5'd0;
        w_dec_noblock  = 1'b0;
        w_dec_wait_dma = 1'b0;
        w_dec_jump_pc  = 12'd0;
        w_dec_word     = 32'd0;
        w_dec_err      = 1'b1;
        if (!w_oor) begin
            w_dec_opcode   = i_imem_rdata[31:27];
            w_dec_noblock  = i_imem_rdata[26];
            w_dec_wait_dma = i_imem_rdata[25];
            w_dec_jump_pc  = i_imem_rdata[11:0];
            w_dec_word     = i_imem_rdata;
            w_dec_err      = w_illegal | i_imem_rerr;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_cnt_nxt     = r_cnt;
        w_ovf_nxt     = r_ovf;
        w_capture     = 1'b0;
        if (i_start) begin
            w_state_nxt   = S_IDLE;
            w_pc_nxt      = 12'd0;
            w_pend_nxt    = 1'b0;
            w_pend_pc_nxt = 12'd0;
            w_cnt_nxt     = 2'd0;
            w_ovf_nxt     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_fetch_en) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = i_pc;
                    end
                end
                S_REQ: begin
                    // Out-of-range requests skip the ce but still sit out the read slot,
                    // keeping the request-to-valid latency fixed.
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 2'd0;
                end
                S_WAIT: begin
                    if (r_cnt == LAST_CNT) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DEC;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
                S_DEC: begin
                    if (r_pend) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = r_pend_pc;
                        w_pend_nxt  = 1'b0;
                    end else if (i_fetch_en) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = i_pc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            // In DEC a request with an empty slot was already routed straight to REQ above.
            if (i_fetch_en && (r_state != S_IDLE)) begin
                if (r_pend) begin
                    w_ovf_nxt = 1'b1;
                end else if (r_state != S_DEC) begin
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = i_pc;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= 12'd0;
            r_pend    <= 1'b0;
            r_pend_pc <= 12'd0;
            r_cnt     <= 2'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_opcode   <= 5'd0;
            r_noblock  <= 1'b0;
            r_wait_dma <= 1'b0;
            r_jump_pc  <= 12'd0;
            r_word     <= 32'd0;
            r_err      <= 1'b0;
        end else if (i_start) begin
            r_opcode   <= 5'd0;
            r_noblock  <= 1'b0;
            r_wait_dma <= 1'b0;
            r_jump_pc  <= 12'd0;
            r_word     <= 32'd0;
            r_err      <= 1'b0;
        end else if (w_capture) begin
            r_opcode   <= w_dec_opcode;
            r_noblock  <= w_dec_noblock;
            r_wait_dma <= w_dec_wait_dma;
            r_jump_pc  <= w_dec_jump_pc;
            r_word     <= w_dec_word;
            r_err      <= w_dec_err;
        end
    end

    assign o_imem_ce               = (r_state == S_REQ) && !w_oor;
    assign o_imem_addr             = ADDR_W'(r_pc);
    assign o_inst_valid            = (r_state == S_DEC);
    assign o_opcode                = r_opcode;
    assign o_be_noblock            = r_noblock;
    assign o_wait_last_noblock_dma = r_wait_dma;
    assign o_jump_pc               = r_jump_pc;
    assign o_inst_word             = r_word;
    assign o_err_inst              = r_err;
    assign o_busy                  = (r_state != S_IDLE) || r_pend;
    assign o_fetch_ovf             = r_ovf;

endmodule

// File: tb/tb_npu_inst_fetch.sv
// Scoreboard bench for npu_inst_fetch: two instances (RD_LAT=1/PROG_LEN=16 and RD_LAT=3/default)
// with small behavioural SRAMs; stimulus queues expected pulses, negedge monitors consume them.
module tb_npu_inst_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int          cyc;
        logic [51:0] fld;
    } exp_t;

    typedef struct packed {
        int          cyc;
        logic [11:0] addr;
    } ce_t;

    exp_t qa_v[$];
    exp_t qb_v[$];
    ce_t  qa_c[$];
    ce_t  qb_c[$];
    exp_t ea, eb;
    ce_t  ca, cb;

    logic [31:0] mema  [16];
    logic        rerra [16];
    logic [31:0] memb  [16];

    // Instance A: RD_LAT=1, PROG_LEN=16
    logic        a_start, a_fetch_en, a_ce, a_rerr, a_valid, a_nb, a_wt, a_err, a_busy, a_ovf;
    logic [11:0] a_pc, a_addr, a_jp;
    logic [31:0] a_rdata, a_word;
    logic [4:0]  a_op;
    logic        a_v1 = 1'b0;
    logic [3:0]  a_a1 = 4'd0;

    always @(posedge clk) begin
        a_v1 <= a_ce;
        a_a1 <= a_addr[3:0];
    end
    assign a_rdata = a_v1 ? mema[a_a1] : 32'hDEAD_BEEF;
    assign a_rerr  = a_v1 & rerra[a_a1];

    npu_inst_fetch #(.RD_LAT(1), .ADDR_W(12), .PROG_LEN(16)) u_dut_a (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_start                 (a_start),
        .i_fetch_en              (a_fetch_en),
        .i_pc                    (a_pc),
        .o_imem_ce               (a_ce),
        .o_imem_addr             (a_addr),
        .i_imem_rdata            (a_rdata),
        .i_imem_rerr             (a_rerr),
        .o_inst_valid            (a_valid),
        .o_opcode                (a_op),
        .o_be_noblock            (a_nb),
        .o_wait_last_noblock_dma (a_wt),
        .o_jump_pc               (a_jp),
        .o_inst_word             (a_word),
        .o_err_inst              (a_err),
        .o_busy                  (a_busy),
        .o_fetch_ovf             (a_ovf)
    );

    // Instance B: RD_LAT=3, PROG_LEN=4096
    logic        b_start, b_fetch_en, b_ce, b_rerr, b_valid, b_nb, b_wt, b_err, b_busy, b_ovf;
    logic [11:0] b_pc, b_addr, b_jp;
    logic [31:0] b_rdata, b_word;
    logic [4:0]  b_op;
    logic [2:0]  b_v = 3'b000;
    logic [3:0]  b_a0 = 4'd0, b_a1 = 4'd0, b_a2 = 4'd0;

    always @(posedge clk) begin
        b_v  <= {b_v[1:0], b_ce};
        b_a0 <= b_addr[3:0];
        b_a1 <= b_a0;
        b_a2 <= b_a1;
    end
    assign b_rdata = b_v[2] ? memb[b_a2] : 32'hDEAD_BEEF;
    assign b_rerr  = 1'b0;

    npu_inst_fetch #(.RD_LAT(3), .ADDR_W(12), .PROG_LEN(4096)) u_dut_b (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_start                 (b_start),
        .i_fetch_en              (b_fetch_en),
        .i_pc                    (b_pc),
        .o_imem_ce               (b_ce),
        .o_imem_addr             (b_addr),
        .i_imem_rdata            (b_rdata),
        .i_imem_rerr             (b_rerr),
        .o_inst_valid            (b_valid),
        .o_opcode                (b_op),
        .o_be_noblock            (b_nb),
        .o_wait_last_noblock_dma (b_wt),
        .o_jump_pc               (b_jp),
        .o_inst_word             (b_word),
        .o_err_inst              (b_err),
        .o_busy                  (b_busy),
        .o_fetch_ovf             (b_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: pulse at cycle %0d with nothing expected", name, cyc);
    endtask

    function automatic logic [51:0] f(input logic [4:0] op, input logic nb, input logic wt,
                                      input logic [11:0] jp, input logic [31:0] w,
                                      input logic err);
        return {op, nb, wt, jp, w, err};
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid) begin
                if (qa_v.size() == 0) unexpected("a_valid");
                else begin
                    ea = qa_v.pop_front();
                    chk("a_valid_cycle", 64'(cyc), 64'(ea.cyc));
                    chk("a_fields", 64'({a_op, a_nb, a_wt, a_jp, a_word, a_err}), 64'(ea.fld));
                end
            end
            if (a_ce) begin
                if (qa_c.size() == 0) unexpected("a_ce");
                else begin
                    ca = qa_c.pop_front();
                    chk("a_ce_cycle", 64'(cyc), 64'(ca.cyc));
                    chk("a_ce_addr", 64'(a_addr), 64'(ca.addr));
                end
            end
            if (b_valid) begin
                if (qb_v.size() == 0) unexpected("b_valid");
                else begin
                    eb = qb_v.pop_front();
                    chk("b_valid_cycle", 64'(cyc), 64'(eb.cyc));
                    chk("b_fields", 64'({b_op, b_nb, b_wt, b_jp, b_word, b_err}), 64'(eb.fld));
                end
            end
            if (b_ce) begin
                if (qb_c.size() == 0) unexpected("b_ce");
                else begin
                    cb = qb_c.pop_front();
                    chk("b_ce_cycle", 64'(cyc), 64'(cb.cyc));
                    chk("b_ce_addr", 64'(b_addr), 64'(cb.addr));
                end
            end
        end
    end

    task automatic a_fetch(input logic [11:0] pc, input logic ce_exp, input logic [51:0] fld);
        @(posedge clk); #1;
        qa_v.push_back('{cyc + 3, fld});
        if (ce_exp) qa_c.push_back('{cyc + 1, pc});
        a_fetch_en = 1'b1;
        a_pc       = pc;
        @(posedge clk); #1;
        a_fetch_en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic b_fetch(input logic [11:0] pc, input logic [51:0] fld);
        @(posedge clk); #1;
        qb_v.push_back('{cyc + 5, fld});
        qb_c.push_back('{cyc + 1, pc});
        b_fetch_en = 1'b1;
        b_pc       = pc;
        @(posedge clk); #1;
        b_fetch_en = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        a_start    = 1'b0;
        a_fetch_en = 1'b0;
        a_pc       = 12'd0;
        b_start    = 1'b0;
        b_fetch_en = 1'b0;
        b_pc       = 12'd0;
        for (int i = 0; i < 16; i++) begin
            mema[i]  = 32'd0;
            rerra[i] = 1'b0;
            memb[i]  = 32'd0;
        end
        mema[1]  = 32'h5200_0007;
        mema[2]  = 32'h6C00_0ABC;
        mema[3]  = 32'h0800_0000;
        mema[4]  = 32'h1234_5678;
        mema[5]  = 32'h9400_0123;
        mema[6]  = 32'hE000_0040;
        rerra[6] = 1'b1;
        mema[15] = 32'hB800_0001;
        memb[7]  = 32'h5E00_0055;
        memb[8]  = 32'h3000_0001;
        memb[9]  = 32'hFF00_0FFF;

        repeat (2) @(posedge clk); #1;
        chk("rst_a_ctrl", 64'({a_ce, a_addr, a_valid, a_busy, a_ovf}), 64'd0);
        chk("rst_a_fields", 64'({a_op, a_nb, a_wt, a_jp, a_word, a_err}), 64'd0);
        chk("rst_b_ctrl", 64'({b_ce, b_addr, b_valid, b_busy, b_ovf}), 64'd0);
        chk("rst_b_fields", 64'({b_op, b_nb, b_wt, b_jp, b_word, b_err}), 64'd0);
        rst_n = 1'b1;

        // T1 basic latency and decode
        a_fetch(12'h005, 1'b1, f(5'b10010, 1'b1, 1'b0, 12'h123, 32'h9400_0123, 1'b0));
        chk("a_idle_after_t1", 64'(a_busy), 64'd0);
        chk("a_hold_jump", 64'(a_jp), 64'h123);

        // T2 illegal opcode
        a_fetch(12'h003, 1'b1, f(5'b00001, 1'b0, 1'b0, 12'h000, 32'h0800_0000, 1'b1));

        // T3 out of range (no ce), then last legal PC
        a_fetch(12'h010, 1'b0, f(5'd0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1));
        a_fetch(12'h00F, 1'b1, f(5'b10111, 1'b0, 1'b0, 12'h001, 32'hB800_0001, 1'b0));

        // T4 back-to-back with pending slot, third request dropped
        @(posedge clk); #1;
        qa_v.push_back('{cyc + 3, f(5'b01010, 1'b0, 1'b1, 12'h007, 32'h5200_0007, 1'b0)});
        qa_c.push_back('{cyc + 1, 12'h001});
        qa_v.push_back('{cyc + 6, f(5'b01101, 1'b1, 1'b0, 12'hABC, 32'h6C00_0ABC, 1'b0)});
        qa_c.push_back('{cyc + 4, 12'h002});
        a_fetch_en = 1'b1;
        a_pc       = 12'h001;
        @(posedge clk); #1;
        a_fetch_en = 1'b0;
        @(posedge clk); #1;
        chk("a_busy_in_wait", 64'(a_busy), 64'd1);
        a_fetch_en = 1'b1;
        a_pc       = 12'h002;
        @(posedge clk); #1;
        a_pc       = 12'h004;
        @(posedge clk); #1;
        a_fetch_en = 1'b0;
        chk("a_ovf_set", 64'(a_ovf), 64'd1);
        repeat (5) @(posedge clk); #1;
        chk("a_ovf_sticky", 64'(a_ovf), 64'd1);

        // T6 SRAM error on a legal JUMP word
        a_fetch(12'h006, 1'b1, f(5'b11100, 1'b0, 1'b0, 12'h040, 32'hE000_0040, 1'b1));

        // start clears overflow and zeroes fields
        @(posedge clk); #1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("a_ovf_cleared", 64'(a_ovf), 64'd0);
        chk("a_fields_cleared", 64'({a_op, a_nb, a_wt, a_jp, a_word, a_err}), 64'd0);

        // Instance B: RD_LAT=3 latency, then T5 abort during WAIT
        b_fetch(12'h007, f(5'b01011, 1'b1, 1'b1, 12'h055, 32'h5E00_0055, 1'b0));
        @(posedge clk); #1;
        qb_c.push_back('{cyc + 1, 12'h008});
        b_fetch_en = 1'b1;
        b_pc       = 12'h008;
        @(posedge clk); #1;
        b_fetch_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        chk("b_abort_busy", 64'(b_busy), 64'd0);
        chk("b_abort_fields", 64'({b_op, b_nb, b_wt, b_jp, b_word, b_err}), 64'd0);
        repeat (4) @(posedge clk); #1;
        chk("b_abort_fields_later", 64'({b_op, b_nb, b_wt, b_jp, b_word, b_err}), 64'd0);

        // fetch in the same cycle as start is ignored
        b_start    = 1'b1;
        b_fetch_en = 1'b1;
        b_pc       = 12'h009;
        @(posedge clk); #1;
        b_start    = 1'b0;
        b_fetch_en = 1'b0;
        chk("b_start_wins", 64'(b_busy), 64'd0);
        repeat (6) @(posedge clk);

        b_fetch(12'h009, f(5'b11111, 1'b1, 1'b1, 12'hFFF, 32'hFF00_0FFF, 1'b0));

        repeat (8) @(posedge clk); #1;
        chk("qa_valid_drained", 64'(qa_v.size()), 64'd0);
        chk("qa_ce_drained", 64'(qa_c.size()), 64'd0);
        chk("qb_valid_drained", 64'(qb_v.size()), 64'd0);
        chk("qb_ce_drained", 64'(qb_c.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
